// File: rtl/mem_access_stage.sv
// Memory access stage of the RV32 pipeline: issues aligned data-memory requests,
// waits for load data and hands the raw word plus write-back controls downstream.
module mem_access_stage #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [SIZE-1:0] ALU_result,
    input  logic [SIZE-1:0] rs2_data,
    input  logic            WB_select_in,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [SIZE-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [SIZE-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [SIZE-1:0] dmem_rdata,
    output logic            out_valid,
    output logic [SIZE-1:0] r_data,
    output logic [SIZE-1:0] ALU_result_out,
    output logic [2:0]      funct3_out,
    output logic            WB_select_out,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            misaligned_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t          state_q, state_d;

    // Instruction captured at accept
    logic            is_store_q, is_store_d;
    logic            exc_q, exc_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            wb_sel_q, wb_sel_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;

    // Registered results presented to write-back
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] r_data_q, r_data_d;
    logic [SIZE-1:0] alu_out_q, alu_out_d;
    logic [2:0]      funct3_out_q, funct3_out_d;
    logic            wb_sel_out_q, wb_sel_out_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            reg_write_out_q, reg_write_out_d;
    logic            exc_out_q, exc_out_d;

    logic            mem_op;
    logic            misaligned_in;
    logic [3:0]      be_in;
    logic [SIZE-1:0] wdata_in;

    assign mem_op = mem_read | mem_write;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        misaligned_in = 1'b0;
        be_in         = 4'b0000;
        wdata_in      = rs2_data;
        case (funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << ALU_result[1:0];
                wdata_in = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be_in         = 4'b0011 << {ALU_result[1], 1'b0};
                wdata_in      = {2{rs2_data[15:0]}};
                misaligned_in = ALU_result[0];
            end
            2'b10: begin
                be_in         = 4'b1111;
                misaligned_in = |ALU_result[1:0];
            end
            default: misaligned_in = 1'b1;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        is_store_d      = is_store_q;
        exc_d           = exc_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        funct3_d        = funct3_q;
        wb_sel_d        = wb_sel_q;
        rd_d            = rd_q;
        reg_write_d     = reg_write_q;
        out_valid_d     = 1'b0;
        r_data_d        = r_data_q;
        alu_out_d       = alu_out_q;
        funct3_out_d    = funct3_out_q;
        wb_sel_out_d    = wb_sel_out_q;
        rd_out_d        = rd_out_q;
        reg_write_out_d = reg_write_out_q;
        exc_out_d       = exc_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    is_store_d  = mem_write;
                    exc_d       = mem_op & misaligned_in;
                    addr_d      = ALU_result;
                    be_d        = be_in;
                    wdata_d     = wdata_in;
                    funct3_d    = funct3;
                    wb_sel_d    = WB_select_in;
                    rd_d        = rd_in;
                    reg_write_d = reg_write_in;
                    // Faulting accesses skip the bus entirely
                    state_d     = (mem_op && !misaligned_in) ? REQ : DONE;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_d = is_store_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    r_data_d = dmem_rdata;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid_d     = 1'b1;
                alu_out_d       = addr_q;
                funct3_out_d    = funct3_q;
                wb_sel_out_d    = wb_sel_q;
                rd_out_d        = rd_q;
                reg_write_out_d = reg_write_q & ~exc_q & ~is_store_q;
                exc_out_d       = exc_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            is_store_q      <= 1'b0;
            exc_q           <= 1'b0;
            addr_q          <= '0;
            be_q            <= 4'b0000;
            wdata_q         <= '0;
            funct3_q        <= 3'b000;
            wb_sel_q        <= 1'b0;
            rd_q            <= 5'd0;
            reg_write_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            r_data_q        <= '0;
            alu_out_q       <= '0;
            funct3_out_q    <= 3'b000;
            wb_sel_out_q    <= 1'b0;
            rd_out_q        <= 5'd0;
            reg_write_out_q <= 1'b0;
            exc_out_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_store_q      <= is_store_d;
            exc_q           <= exc_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            funct3_q        <= funct3_d;
            wb_sel_q        <= wb_sel_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            out_valid_q     <= out_valid_d;
            r_data_q        <= r_data_d;
            alu_out_q       <= alu_out_d;
            funct3_out_q    <= funct3_out_d;
            wb_sel_out_q    <= wb_sel_out_d;
            rd_out_q        <= rd_out_d;
            reg_write_out_q <= reg_write_out_d;
            exc_out_q       <= exc_out_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_addr      = {addr_q[SIZE-1:2], 2'b00};
    assign dmem_we        = is_store_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;

    assign out_valid      = out_valid_q;
    assign r_data         = r_data_q;
    assign ALU_result_out = alu_out_q;
    assign funct3_out     = funct3_out_q;
    assign WB_select_out  = wb_sel_out_q;
    assign rd_out         = rd_out_q;
    assign reg_write_out  = reg_write_out_q;
    assign misaligned_exc = exc_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset corner case and
// randomized transactions checked against a transaction-level reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ALU_result = '0;
    logic [31:0] rs2_data = '0;
    logic        WB_select_in = 1'b0;
    logic [4:0]  rd_in = 5'd0;
    logic        reg_write_in = 1'b0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        out_valid;
    logic [31:0] r_data;
    logic [31:0] ALU_result_out;
    logic [2:0]  funct3_out;
    logic        WB_select_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        misaligned_exc;

    int n_cmp = 0;
    int n_fail = 0;

    mem_access_stage #(.SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .ALU_result(ALU_result), .rs2_data(rs2_data),
        .WB_select_in(WB_select_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .r_data(r_data),
        .ALU_result_out(ALU_result_out), .funct3_out(funct3_out),
        .WB_select_out(WB_select_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .misaligned_exc(misaligned_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu, rs2, rdata;
        logic [4:0]  rd;
        logic        rw, wb;
        int          req_wait, rsp_wait;
        logic        spur;
        logic        exp_req, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_exc, exp_rw;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(logic mr, logic mw, logic [2:0] f3, logic [31:0] alu,
                                 logic [31:0] rs2, logic [31:0] rdata, logic [4:0] rd,
                                 logic rw, logic wb, int req_wait, int rsp_wait, logic spur);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
        v.rd = rd; v.rw = rw; v.wb = wb; v.req_wait = req_wait; v.rsp_wait = rsp_wait;
        v.spur = spur;
        v.exp_req = 0; v.exp_we = 0; v.exp_be = 0; v.exp_wdata = 0;
        v.exp_exc = 0; v.exp_rw = 0; v.exp_lat = 0; v.exp_rdata = 0;
        return v;
    endfunction

    function automatic vec_t setexp(vec_t v, logic req, logic we, logic [3:0] be,
                                    logic [31:0] wdata, logic exc, logic rw, int lat,
                                    logic [31:0] rdata);
        vec_t e = v;
        e.exp_req = req; e.exp_we = we; e.exp_be = be; e.exp_wdata = wdata;
        e.exp_exc = exc; e.exp_rw = rw; e.exp_lat = lat; e.exp_rdata = rdata;
        return e;
    endfunction

    // Transaction-level reference: access size in bytes, lane arithmetic, latency sum.
    function automatic vec_t model(vec_t v, logic [31:0] prev_rdata);
        vec_t e = v;
        int sz;
        int off;
        logic [31:0] w;
        sz  = 1 << int'(v.f3[1:0]);
        off = int'(v.alu[1:0]);
        e.exp_exc = (v.mr || v.mw) && (v.f3[1:0] == 2'b11 || (off % sz) != 0);
        e.exp_req = (v.mr || v.mw) && !e.exp_exc;
        e.exp_we  = v.mw;
        e.exp_be  = 4'(((1 << sz) - 1) << off);
        w = '0;
        for (int lane = 0; lane < 4; lane++)
            w[8*lane +: 8] = v.rs2[8*(lane % sz) +: 8];
        e.exp_wdata = w;
        e.exp_rw    = v.rw && !e.exp_exc && !v.mw;
        if (!e.exp_req)  e.exp_lat = 2;
        else if (v.mw)   e.exp_lat = 3 + v.req_wait;
        else             e.exp_lat = 4 + v.req_wait + v.rsp_wait;
        e.exp_rdata = (e.exp_req && !v.mw) ? v.rdata : prev_rdata;
        return e;
    endfunction

    // Presents one instruction, plays the memory, and checks the result pulse.
    task automatic run_txn(input vec_t v, input string tag);
        int  c;
        int  req_cnt;
        int  rsp_cnt;
        int  seen;
        bit  hs;
        bit  got;
        bit  req_ok;
        bit  busy_ok;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; mem_read = v.mr; mem_write = v.mw; funct3 = v.f3;
        ALU_result = v.alu; rs2_data = v.rs2; rd_in = v.rd;
        reg_write_in = v.rw; WB_select_in = v.wb;
        step();
        in_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); ALU_result = $urandom; rs2_data = $urandom;
        rd_in = 5'($urandom); reg_write_in = 1'($urandom); WB_select_in = 1'($urandom);
        c = 1; req_cnt = 0; rsp_cnt = 0; seen = 0;
        hs = 0; got = 0; req_ok = 1; busy_ok = 1;
        while (c < 40) begin
            if (out_valid) begin
                got = 1;
                break;
            end
            if (in_ready) busy_ok = 0;
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = $urandom;
            if (dmem_req_valid) begin
                seen++;
                if (dmem_addr !== (v.alu & ~32'h3) || dmem_be !== v.exp_be ||
                    dmem_wdata !== v.exp_wdata || dmem_we !== v.exp_we)
                    req_ok = 0;
                if (req_cnt == v.req_wait) begin
                    dmem_req_ready = 1'b1;
                    hs = 1;
                end
                req_cnt++;
                if (v.spur) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rdata     = 32'hDEAD_BEEF;
                end
            end else if (hs && !v.exp_we) begin
                if (rsp_cnt == v.rsp_wait) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rdata     = v.rdata;
                end
                rsp_cnt++;
            end
            step();
            c++;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (!got) check({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(c), 32'(v.exp_lat));
        check({tag, "_req_count"}, 32'(seen), v.exp_req ? 32'(v.req_wait + 1) : 32'd0);
        if (v.exp_req) check({tag, "_req_fields"}, 32'(req_ok), 32'd1);
        check({tag, "_busy_in_ready"}, 32'(busy_ok), 32'd1);
        check({tag, "_exc"}, 32'(misaligned_exc), 32'(v.exp_exc));
        check({tag, "_reg_write_out"}, 32'(reg_write_out), 32'(v.exp_rw));
        check({tag, "_alu_out"}, ALU_result_out, v.alu);
        check({tag, "_funct3_out"}, 32'(funct3_out), 32'(v.f3));
        check({tag, "_rd_out"}, 32'(rd_out), 32'(v.rd));
        check({tag, "_wb_sel_out"}, 32'(WB_select_out), 32'(v.wb));
        check({tag, "_r_data"}, r_data, v.exp_rdata);
    endtask

    vec_t tbl[8];

    initial begin
        vec_t        v;
        logic [31:0] r_model;
        bit          no_pulse;

        tbl[0] = setexp(mkv(0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 1, 0, 0, 0),
                        0, 0, 4'b0000, 32'h0, 0, 1, 2, 32'h0);
        tbl[1] = setexp(mkv(0, 1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 5'd7, 1, 0, 3, 0, 0),
                        1, 1, 4'b1000, 32'hDDDD_DDDD, 0, 0, 6, 32'h0);
        tbl[2] = setexp(mkv(1, 0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 5'd9, 1, 0, 0, 2, 0),
                        1, 0, 4'b1100, 32'h0, 0, 1, 6, 32'h8001_7FFF);
        tbl[3] = setexp(mkv(1, 0, 3'b010, 32'h0000_0301, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0),
                        0, 0, 4'b0000, 32'h0, 1, 0, 2, 32'h8001_7FFF);
        tbl[4] = setexp(mkv(1, 0, 3'b011, 32'h0000_0300, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0),
                        0, 0, 4'b0000, 32'h0, 1, 0, 2, 32'h8001_7FFF);
        tbl[5] = setexp(mkv(0, 1, 3'b010, 32'h0000_0040, 32'h1234_5678, 32'h0, 5'd11, 1, 0, 0, 0, 0),
                        1, 1, 4'b1111, 32'h1234_5678, 0, 0, 3, 32'h8001_7FFF);
        tbl[6] = setexp(mkv(1, 0, 3'b100, 32'h0000_0041, 32'h0, 32'hCAFE_F00D, 5'd12, 1, 1, 1, 1, 1),
                        1, 0, 4'b0010, 32'h0, 0, 1, 6, 32'hCAFE_F00D);
        tbl[7] = setexp(mkv(1, 1, 3'b001, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 5'd13, 1, 0, 0, 0, 0),
                        1, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0, 3, 32'hCAFE_F00D);

        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_r_data", r_data, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load waits for its response
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        ALU_result = 32'h0000_0500; rd_in = 5'd3; reg_write_in = 1'b1;
        step();
        in_valid = 1'b0; dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("wait_rsp_in_ready", 32'(in_ready), 32'd0);
        check("wait_rsp_req_valid", 32'(dmem_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_r_data", r_data, 32'h0);
        check("midrst_alu_out", ALU_result_out, 32'h0);
        check("midrst_rd_out", 32'(rd_out), 32'd0);
        check("midrst_dmem_addr", dmem_addr, 32'h0);
        check("midrst_outputs_low",
              32'({dmem_we, dmem_be, misaligned_exc, reg_write_out, WB_select_out, funct3_out}),
              32'd0);
        step();
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0000_0055;
        step();
        dmem_rsp_valid = 1'b0;
        no_pulse = 1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) no_pulse = 0;
            step();
        end
        check("postrst_no_out_valid", 32'(no_pulse), 32'd1);
        check("postrst_r_data", r_data, 32'h0);
        check("postrst_in_ready", 32'(in_ready), 32'd1);

        r_model = 32'h0;
        for (int i = 0; i < 60; i++) begin
            v = mkv(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    5'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
            v = model(v, r_model);
            r_model = v.exp_rdata;
            run_txn(v, $sformatf("rnd%0d", i));
        end
        step();
        check("final_single_pulse", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the RV32 pipeline. Sits between execute and the combinational write-back stage.
- Issues data-memory requests over a valid/ready bus and aligns store data and byte enables.
- Waits for load responses, then hands the raw memory word, ALU result, funct3 and write-back controls to write-back.
- Byte/half extraction and sign extension stay in write-back.

Parameters:
SIZE, 32, data/address width (RV32 only; byte-enable logic fixed at 4 lanes)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  execute presents an instruction
in_ready  output  1  stage can accept; high only in IDLE
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
funct3  input  3  RISC-V width/sign field
ALU_result  input  SIZE  effective address or ALU value
rs2_data  input  SIZE  store source
WB_select_in  input  1  write-back mux select, passed through
rd_in  input  5  destination register
reg_write_in  input  1  register write enable
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  SIZE  word-aligned address ({addr[31:2],2'b00})
dmem_we  output  1  1 = store
dmem_be  output  4  byte enables
dmem_wdata  output  SIZE  lane-replicated store data
dmem_rsp_valid  input  1  load data valid
dmem_rdata  input  SIZE  load data word
out_valid  output  1  one-cycle pulse: result for write-back
r_data  output  SIZE  captured memory word
ALU_result_out  output  SIZE  registered ALU_result
funct3_out  output  3  registered funct3
WB_select_out  output  1  registered WB_select_in
rd_out  output  5  registered rd_in
reg_write_out  output  1  gated write enable
misaligned_exc  output  1  valid with out_valid; access faulted

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low.
- Reset: state=IDLE. Every output register returns to 0, including out_valid, dmem_req_valid and misaligned_exc. in_ready=1 after reset.
- Reset mid-transaction: the access is abandoned and no out_valid is produced. A dmem_rsp_valid arriving in IDLE is ignored.
- Accept: in_valid && in_ready latches all inputs. Mem op = mem_read|mem_write. If both are set, the instruction is treated as a store.
- Width decode uses funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- Misaligned when: half with addr[0]=1, word with addr[1:0]!=0, or illegal width.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, non-mem accept -> DONE.
- IDLE, mem accept, misaligned -> DONE with misaligned_exc=1 and reg_write_out=0. No bus request is made.
- IDLE, mem accept, aligned -> REQ.
- REQ: dmem_req_valid=1 with addr/we/be/wdata held stable until dmem_req_ready.
  - Handshake on a store -> DONE.
  - Handshake on a load -> WAIT_RSP.
  - dmem_rsp_valid in REQ is ignored.
- WAIT_RSP: on dmem_rsp_valid, capture dmem_rdata into r_data -> DONE. Waits indefinitely.
- DONE: out_valid=1 for exactly one cycle -> IDLE. Outputs hold their values until the next DONE.
- reg_write_out: reg_write_in && !misaligned && !store.
- r_data: updates only on load response, otherwise holds.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - Loads drive the same be pattern.
- Store data: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Latency from accept cycle T, with zero-wait memory:
  - non-mem: out_valid at T+2.
  - misaligned: out_valid at T+2.
  - store: req at T+1, out_valid at T+3.
  - load: req at T+1, rsp at T+2 or later, out_valid at rsp cycle+2.
- Each extra cycle of dmem_req_ready=0 or rsp delay adds one cycle.
- in_ready=0 outside IDLE. Upstream must hold its instruction while stalled.
- No back-pressure from write-back.

Test Plan:
- Non-mem instruction: ALU_result=0x0000_1234, rd=5, reg_write=1, WB_select=1 -> out_valid at T+2 with ALU_result_out=0x1234, rd_out=5, reg_write_out=1, misaligned_exc=0, dmem_req_valid never high.
- SB at addr 0x103, rs2=0xAABB_CCDD -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDD_DDDD, we=1. Hold dmem_req_ready=0 for 3 cycles: request held stable, in_ready=0. Then out_valid with reg_write_out=0.
- LH at addr 0x202, funct3=3'b001, rsp 2 cycles late with rdata=0x8001_7FFF -> be=4'b1100, r_data=0x8001_7FFF, funct3_out=3'b001, ALU_result_out=0x202, single out_valid pulse.
- LW at 0x301 -> no request, out_valid at T+2 with misaligned_exc=1, reg_write_out=0. Repeat with funct3=3'b011 at 0x300 -> same exception.
- Reset: deassert rst_n while in WAIT_RSP, then pulse dmem_rsp_valid after release -> all outputs 0, no out_valid, in_ready=1.
- Back-to-back SW then LB, with dmem_rsp_valid already asserted during the LB request cycle -> that response is ignored. Only a later rsp is captured; exactly two out_valid pulses total.
